axi_ram_rd_dma: RTL and testbench

//  Read-side burst controller for the on-chip AXI RAM wrapper (no-ID AXI4 subset).

---
 rtl/axi_ram_rd_dma.sv | 126 ++++++++++++
 tb/tb_axi_ram_rd_dma.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_rd_dma.sv
// rtl/axi_ram_rd_dma.sv - read-side AXI burst controller with max-length and 4 KB splitting
// One burst outstanding; R beats pass straight through to the consumer.
module axi_ram_rd_dma #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_beats,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [7:0]            s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [8:0]            bcnt;
  logic                  err;
  logic [31:0]           room;
  logic [31:0]           blen;
  logic                  r_hs;
  logic                  burst_end;

  assign s_axi_arsize  = 3'(SZ);
  assign s_axi_arburst = 2'b01;
  assign out_data      = s_axi_rdata;
  assign r_hs          = (state == DATA) && s_axi_rvalid && out_ready;
  assign burst_end     = (bcnt == 9'd1);

  // Beats left before the next 4 KB page, then clamp by max length and remaining count
  always_comb begin
    room = (32'd4096 - 32'(addr[11:0])) >> SZ;
    blen = 32'(remaining);
    if (blen > 32'(MAX_BURST_LEN)) blen = 32'(MAX_BURST_LEN);
    if (blen > room) blen = room;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      bcnt         <= '0;
      err          <= 1'b0;
      s_axi_araddr <= '0;
      s_axi_arlen  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        addr      <= cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
        remaining <= cmd_beats;
        err       <= 1'b0;
      end
      if (state == CALC && remaining != '0) begin
        s_axi_araddr <= addr;
        s_axi_arlen  <= 8'(blen - 32'd1);
        bcnt         <= 9'(blen);
      end
      // The beat counter decides burst end; a wrong rlast is only reported
      if (r_hs) begin
        bcnt      <= bcnt - 9'd1;
        remaining <= remaining - CNT_WIDTH'(1);
        if (s_axi_rresp != 2'b00 || s_axi_rlast != burst_end) err <= 1'b1;
        if (burst_end) addr <= addr + ((ADDR_WIDTH'(s_axi_arlen) + ADDR_WIDTH'(1)) << SZ);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    s_axi_arvalid = 1'b0;
    out_valid     = 1'b0;
    s_axi_rready  = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) state_nxt = CALC;
      end
      CALC: state_nxt = (remaining == '0) ? DONE : ADDR;
      ADDR: begin
        s_axi_arvalid = 1'b1;
        if (s_axi_arready) state_nxt = DATA;
      end
      DATA: begin
        out_valid    = s_axi_rvalid;
        s_axi_rready = out_ready;
        out_last     = burst_end && (remaining == CNT_WIDTH'(1));
        if (r_hs && burst_end) state_nxt = (remaining == CNT_WIDTH'(1)) ? DONE : CALC;
      end
      DONE: begin
        done      = 1'b1;
        done_err  = err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_ram_rd_dma.sv
// tb/tb_axi_ram_rd_dma.sv - directed self-checking bench for axi_ram_rd_dma
// A behavioural AXI RAM slave serves reads; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_axi_ram_rd_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] out_data;
  logic        out_last, out_valid;
  logic        out_ready = 1'b0;
  logic        done, done_err;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready = 1'b0;
  logic [31:0] s_axi_rdata = '0;
  logic [1:0]  s_axi_rresp = '0;
  logic        s_axi_rlast = 1'b0;
  logic        s_axi_rvalid = 1'b0;
  logic        s_axi_rready;

  always #5 clk = ~clk;

  axi_ram_rd_dma dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .done_err(done_err),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [15:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [2:0]  ar_size_q[$];
  logic [1:0]  ar_burst_q[$];
  int          ar_cyc_q[$];
  int          bend_cyc_q[$];
  int          done_cyc, done_cnt, rr_bad, ov_bad;
  logic        done_err_v, done_rdy;
  bit          timed_out;
  int          err_beat = -1;
  int          flip_beat = -1;
  int          abort_beat = -1;
  bit          rand_ready = 1'b0;
  logic [15:0] r_addr = '0;
  int          r_left = 0;
  int          beat_idx = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5a5a, a};
  endfunction

  // Cycle 0 is the cycle whose rising edge accepts the command
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] n);
    bit accepted = 1'b0;
    bit ar_prev = 1'b0;
    int cyc = 0;
    got_data.delete(); got_last.delete();
    ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete(); ar_burst_q.delete();
    ar_cyc_q.delete(); bend_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; done_err_v = 1'b0; done_rdy = 1'b1;
    rr_bad = 0; ov_bad = 0; timed_out = 1'b1; beat_idx = 0; r_left = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      cmd_valid     = !accepted;
      cmd_addr      = a;
      cmd_beats     = n;
      out_ready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axi_arready = 1'($urandom_range(0, 1));
      if (r_left > 0) begin
        s_axi_rvalid = 1'b1;
        s_axi_rdata  = mem_word(r_addr);
        s_axi_rlast  = (r_left == 1) ^ (beat_idx == flip_beat);
        s_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
      end else begin
        s_axi_rvalid = 1'b0;
        s_axi_rdata  = '0;
        s_axi_rlast  = 1'b0;
        s_axi_rresp  = 2'b00;
      end
      #1;
      if (accepted) cyc++;
      else if (cmd_ready) accepted = 1'b1;
      if (s_axi_rready !== ((r_left > 0) ? out_ready : 1'b0)) rr_bad++;
      if (out_valid !== s_axi_rvalid) ov_bad++;
      if (s_axi_arvalid && !ar_prev) ar_cyc_q.push_back(cyc);
      ar_prev = s_axi_arvalid;
      if (s_axi_rvalid && s_axi_rready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        beat_idx++;
        r_addr += 16'd4;
        r_left--;
        if (r_left == 0) bend_cyc_q.push_back(cyc);
        if (beat_idx == abort_beat) begin
          timed_out = 1'b0;
          return;
        end
      end
      if (s_axi_arvalid && s_axi_arready) begin
        ar_addr_q.push_back(s_axi_araddr);
        ar_len_q.push_back(s_axi_arlen);
        ar_size_q.push_back(s_axi_arsize);
        ar_burst_q.push_back(s_axi_arburst);
        r_addr = s_axi_araddr;
        r_left = int'(s_axi_arlen) + 1;
      end
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_err_v = done_err;
        done_rdy   = cmd_ready;
        timed_out  = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
    checks++; if (s_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b exp 0", s_axi_arvalid); end
    checks++; if ({done, out_valid, s_axi_rready} !== 3'b000) begin errors++; $display("FAIL rst_outputs: got %b exp 000", {done, out_valid, s_axi_rready}); end
    checks++; if ({s_axi_araddr, s_axi_arlen} !== 24'h0) begin errors++; $display("FAIL rst_ar_fields: got %h exp 0", {s_axi_araddr, s_axi_arlen}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_single_burst();
    int bad = 0;
    run_cmd(16'h0000, 16'd4);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got 1 exp 0"); end
    checks++; if (ar_addr_q.size() != 1) begin errors++; $display("FAIL single_ar_count: got %0d exp 1", ar_addr_q.size()); end
    else begin
      checks++; if ({ar_addr_q[0], ar_len_q[0], ar_size_q[0], ar_burst_q[0]} !== {16'h0000, 8'd3, 3'd2, 2'd1}) begin
        errors++; $display("FAIL single_ar: got %h/%0d/%0d/%0d exp 0000/3/2/1", ar_addr_q[0], ar_len_q[0], ar_size_q[0], ar_burst_q[0]); end
      checks++; if (ar_cyc_q[0] != 2) begin errors++; $display("FAIL single_ar_latency: got %0d exp 2", ar_cyc_q[0]); end
    end
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL single_beats: got %0d exp 4", got_data.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (got_data[i] !== mem_word(16'(4 * i))) bad++;
        if (got_last[i] !== (i == 3)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL single_data_last: got %0d bad beats exp 0", bad); end
      checks++; if (done_cyc != bend_cyc_q[0] + 1) begin errors++; $display("FAIL single_done_latency: got %0d exp %0d", done_cyc, bend_cyc_q[0] + 1); end
    end
    checks++; if (done_err_v !== 1'b0) begin errors++; $display("FAIL single_done_err: got %b exp 0", done_err_v); end
    checks++; if (done_rdy !== 1'b0) begin errors++; $display("FAIL single_ready_in_done: got %b exp 0", done_rdy); end
  endtask

  task automatic test_4k_split();
    int bad = 0;
    run_cmd(16'h0ff8, 16'd6);
    checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL split_ar_count: got %0d exp 2", ar_addr_q.size()); end
    else begin
      checks++; if ({ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]} !== {16'h0ff8, 8'd1, 16'h1000, 8'd3}) begin
        errors++; $display("FAIL split_ar: got %h/%0d %h/%0d exp 0ff8/1 1000/3", ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]); end
      checks++; if (ar_cyc_q.size() != 2 || ar_cyc_q[1] != bend_cyc_q[0] + 2) begin
        errors++; $display("FAIL split_rearm_latency: got %0d exp %0d", ar_cyc_q[ar_cyc_q.size() - 1], bend_cyc_q[0] + 2); end
    end
    checks++; if (got_data.size() != 6) begin errors++; $display("FAIL split_beats: got %0d exp 6", got_data.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        if (got_data[i] !== mem_word(16'h0ff8 + 16'(4 * i))) bad++;
        if (got_last[i] !== (i == 5)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL split_data_last: got %0d bad beats exp 0", bad); end
    end
  endtask

  task automatic test_long_random_ready();
    int bad = 0;
    int lasts = 0;
    rand_ready = 1'b1;
    run_cmd(16'h2000, 16'd600);
    rand_ready = 1'b0;
    checks++; if (timed_out) begin errors++; $display("FAIL long_timeout: got 1 exp 0"); end
    checks++; if (ar_addr_q.size() != 3) begin errors++; $display("FAIL long_ar_count: got %0d exp 3", ar_addr_q.size()); end
    else begin
      checks++; if ({ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1], ar_addr_q[2], ar_len_q[2]} !==
                    {16'h2000, 8'd255, 16'h2400, 8'd255, 16'h2800, 8'd87}) begin
        errors++; $display("FAIL long_ar: got %h/%0d %h/%0d %h/%0d exp 2000/255 2400/255 2800/87",
                           ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1], ar_addr_q[2], ar_len_q[2]); end
    end
    checks++; if (got_data.size() != 600) begin errors++; $display("FAIL long_beats: got %0d exp 600", got_data.size()); end
    else begin
      for (int i = 0; i < 600; i++) begin
        if (got_data[i] !== mem_word(16'h2000 + 16'(4 * i))) bad++;
        if (got_last[i] === 1'b1) lasts++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL long_data: got %0d bad beats exp 0", bad); end
      checks++; if (lasts != 1 || got_last[599] !== 1'b1) begin errors++; $display("FAIL long_last: got %0d lasts exp 1 on beat 600", lasts); end
    end
    checks++; if (rr_bad != 0) begin errors++; $display("FAIL long_rready_mirror: got %0d bad cycles exp 0", rr_bad); end
    checks++; if (ov_bad != 0) begin errors++; $display("FAIL long_out_valid: got %0d bad cycles exp 0", ov_bad); end
  endtask

  task automatic test_rresp_err();
    err_beat = 1;
    run_cmd(16'h0100, 16'd4);
    err_beat = -1;
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL rresp_beats: got %0d exp 4", got_data.size()); end
    checks++; if (done_err_v !== 1'b1) begin errors++; $display("FAIL rresp_done_err: got %b exp 1", done_err_v); end
    run_cmd(16'h0200, 16'd4);
    checks++; if (done_err_v !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL clean_after_err: got err %b done %0d exp 0 1", done_err_v, done_cnt); end
    flip_beat = 1;
    run_cmd(16'h0300, 16'd4);
    flip_beat = -1;
    checks++; if (got_data.size() != 4 || done_err_v !== 1'b1) begin
      errors++; $display("FAIL early_rlast: got %0d beats err %b exp 4 beats err 1", got_data.size(), done_err_v); end
  endtask

  task automatic test_zero_beats();
    run_cmd(16'h0400, 16'd0);
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_done_latency: got %0d exp 2", done_cyc); end
    checks++; if (ar_cyc_q.size() != 0 || done_err_v !== 1'b0) begin
      errors++; $display("FAIL zero_no_ar: got %0d arvalid err %b exp 0 0", ar_cyc_q.size(), done_err_v); end
  endtask

  task automatic test_reset_mid_data();
    int bad = 0;
    abort_beat = 3;
    run_cmd(16'h0500, 16'd8);
    abort_beat = -1;
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL abort_beats: got %0d exp 3", got_data.size()); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, out_valid, s_axi_rready, s_axi_arvalid, done, done_err, out_last} !== 7'b0) begin
      errors++; $display("FAIL abort_async_outputs: got %b exp 0000000",
                         {cmd_ready, out_valid, s_axi_rready, s_axi_arvalid, done, done_err, out_last}); end
    r_left = 0;
    s_axi_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_after: got %b exp 1", cmd_ready); end
    run_cmd(16'h0600, 16'd2);
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] !== mem_word(16'h0600 + 16'(4 * i))) bad++;
    checks++; if (got_data.size() != 2 || bad != 0 || done_err_v !== 1'b0) begin
      errors++; $display("FAIL abort_recover: got %0d beats %0d bad err %b exp 2 0 0", got_data.size(), bad, done_err_v); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_long_random_ready();
    test_rresp_err();
    test_zero_beats();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
